// File: rtl/mseq_pkg.sv
// Shared definitions for the m-sequence generator family.
// Single Galois-LFSR step reused by generators and future checkers.
package mseq_pkg;

  localparam int MAX_W = 32;

  typedef struct packed {
    logic [MAX_W-1:0] s;
    logic             b;
  } step_t;

  function automatic step_t mseq_step(
    input logic [MAX_W-1:0] s,
    input logic [MAX_W:0]   poly
  );
    step_t r;
    r.b = s[0];
    r.s = s >> 1;
    if (s[0])
      r.s = r.s ^ MAX_W'(poly >> 1);
    return r;
  endfunction

endpackage

// File: rtl/mseq_gen_if.sv
// Control and data bundle of the m-sequence generator.
// The slave side is the generator, the master side its user.
interface mseq_if #(
  parameter int W = 4,
  parameter int B = 1
) ();
  localparam int LW = (B > 1) ? $clog2(B) : 1;

  logic          en;
  logic          seed_load;
  logic [W-1:0]  seed;
  logic [B-1:0]  dout;
  logic          dout_valid;
  logic          period_start;
  logic [LW-1:0] start_lane;
  logic [W-1:0]  state;
  logic          seed_err;

  modport master (
    output en, seed_load, seed,
    input  dout, dout_valid, period_start,
    input  start_lane, state, seed_err
  );

  modport slave (
    input  en, seed_load, seed,
    output dout, dout_valid, period_start,
    output start_lane, state, seed_err
  );
endinterface

// File: rtl/mseq_gen_step_unroll.sv
// Combinational B-step unroll of the Galois LFSR.
// Lane k of bits_out is the output of step k.
module mseq_step_unroll
  import mseq_pkg::*;
#(
  parameter int         W    = 4,
  parameter logic [W:0] POLY = 5'b10011,
  parameter int         B    = 1
) (
  input  logic [W-1:0] state_in,
  output logic [W-1:0] state_out,
  output logic [B-1:0] bits_out
);
  localparam logic [MAX_W:0] PX = (MAX_W+1)'(POLY);

  logic [MAX_W-1:0] cur;
  step_t            r;

  // chain B single steps, earliest bit in lane 0
  always_comb begin
    cur      = MAX_W'(state_in);
    r        = '0;
    bits_out = '0;
    for (int k = 0; k < B; k++) begin
      r           = mseq_step(cur, PX);
      bits_out[k] = r.b;
      cur         = r.s;
    end
    state_out = cur[W-1:0];
  end
endmodule

// File: rtl/mseq_gen.sv
// Parametrised Galois-LFSR m-sequence generator, B bits per clock,
// with seed load, zero-seed protection and period-start marking.
module mseq_gen
  import mseq_pkg::*;
#(
  parameter int           W        = 4,
  parameter logic [W:0]   POLY     = 5'b10011,
  parameter int           B        = 1,
  parameter logic [W-1:0] RST_SEED = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic clk,
  input  logic rst,
  mseq_if.slave bus
);
  localparam int         LW  = (B > 1) ? $clog2(B) : 1;
  localparam logic [W:0] PER = {1'b0, {W{1'b1}}};

  logic [W-1:0]  st_q;
  logic [W-1:0]  phase_q;
  logic [B-1:0]  dout_q;
  logic          valid_q;
  logic          ps_q;
  logic [LW-1:0] lane_q;
  logic          err_q;

  logic [W-1:0]  st_nxt;
  logic [B-1:0]  bits;
  logic [W:0]    sum;
  logic [W:0]    q;
  logic [W-1:0]  phase_nxt;
  logic          hit;
  logic [LW-1:0] lane;

  mseq_step_unroll #(
    .W    (W),
    .POLY (POLY),
    .B    (B)
  ) u_unroll (
    .state_in  (st_q),
    .state_out (st_nxt),
    .bits_out  (bits)
  );

  // phase advance mod 2^W-1 and lowest lane holding period bit 0
  always_comb begin
    sum = {1'b0, phase_q} + (W+1)'(B);
    if (sum >= PER)
      phase_nxt = W'(sum - PER);
    else
      phase_nxt = W'(sum);
    hit  = 1'b0;
    lane = '0;
    q    = '0;
    for (int k = B - 1; k >= 0; k--) begin
      q = {1'b0, phase_q} + (W+1)'(k);
      if (q == '0 || q == PER) begin
        hit  = 1'b1;
        lane = LW'(k);
      end
    end
  end

  // state, phase and output word registers; seed load beats enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= RST_SEED;
      phase_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ps_q    <= 1'b0;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else if (bus.seed_load) begin
      st_q    <= (bus.seed == '0) ? W'(1) : bus.seed;
      err_q   <= (bus.seed == '0);
      phase_q <= '0;
      valid_q <= 1'b0;
      ps_q    <= 1'b0;
      lane_q  <= '0;
    end else if (bus.en) begin
      st_q    <= st_nxt;
      phase_q <= phase_nxt;
      dout_q  <= bits;
      valid_q <= 1'b1;
      ps_q    <= hit;
      lane_q  <= hit ? lane : '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ps_q    <= 1'b0;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = valid_q;
  assign bus.period_start = ps_q;
  assign bus.start_lane   = lane_q;
  assign bus.state        = st_q;
  assign bus.seed_err     = err_q;
endmodule

// File: tb/tb_mseq_gen.sv
// Bench for mseq_gen: B=1 and B=4 instances, vector tables,
// corner sequences and random traffic against a behavioural model.
module tb_mseq_gen;
  localparam int PW  = 4;
  localparam int PLY = 19;
  localparam int PRD = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mseq_if #(.W(4), .B(1)) ia ();
  mseq_if #(.W(4), .B(4)) ib ();

  mseq_gen #(
    .W(4), .POLY(5'b10011), .B(1), .RST_SEED(4'h1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  mseq_gen #(
    .W(4), .POLY(5'b10011), .B(4), .RST_SEED(4'h1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  typedef struct {
    logic [3:0] dout;
    logic       ps;
    logic [1:0] lane;
    logic [3:0] st;
  } vec_t;

  vec_t tv[20];

  int bw[2];
  int ms[2], mp[2], md[2], mv[2], mps[2], ml[2], me[2];

  logic [3:0] od, ost;
  logic [1:0] ol;
  logic       ov, ops, oe;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nstate(int s);
    if ((s & 1) != 0) return (s >> 1) ^ (PLY >> 1);
    return s >> 1;
  endfunction

  task automatic model_rst();
    for (int d = 0; d < 2; d++) begin
      ms[d] = 1; mp[d] = 0; md[d] = 0; mv[d] = 0;
      mps[d] = 0; ml[d] = 0; me[d] = 0;
    end
  endtask

  task automatic model_edge(int d, bit e, bit sl, int sd);
    int w;
    if (sl) begin
      me[d] = (sd == 0);
      ms[d] = (sd == 0) ? 1 : sd;
      mp[d] = 0; mv[d] = 0; mps[d] = 0; ml[d] = 0;
    end else if (e) begin
      w = 0; mps[d] = 0; ml[d] = 0;
      for (int k = 0; k < bw[d]; k++) begin
        w |= (ms[d] & 1) << k;
        if (((mp[d] + k) % PRD) == 0 && mps[d] == 0) begin
          mps[d] = 1; ml[d] = k;
        end
        ms[d] = nstate(ms[d]);
      end
      md[d] = w;
      mp[d] = (mp[d] + bw[d]) % PRD;
      mv[d] = 1; me[d] = 0;
    end else begin
      mv[d] = 0; mps[d] = 0; ml[d] = 0; me[d] = 0;
    end
  endtask

  task automatic sample(int d);
    if (d == 0) begin
      od = {3'b0, ia.dout}; ov = ia.dout_valid;
      ops = ia.period_start; ol = {1'b0, ia.start_lane};
      ost = ia.state; oe = ia.seed_err;
    end else begin
      od = ib.dout; ov = ib.dout_valid;
      ops = ib.period_start; ol = ib.start_lane;
      ost = ib.state; oe = ib.seed_err;
    end
  endtask

  task automatic apply(int d, bit e, bit sl, logic [3:0] sd);
    ia.en = (d == 0) ? e : 1'b0;
    ia.seed_load = (d == 0) ? sl : 1'b0;
    ia.seed = sd;
    ib.en = (d == 1) ? e : 1'b0;
    ib.seed_load = (d == 1) ? sl : 1'b0;
    ib.seed = sd;
    model_edge(d, e, sl, int'(sd));
    @(posedge clk);
    #1;
    sample(d);
    chk("m_dout", 32'(od), 32'(md[d]));
    chk("m_valid", 32'(ov), 32'(mv[d]));
    chk("m_ps", 32'(ops), 32'(mps[d]));
    chk("m_lane", 32'(ol), 32'(ml[d]));
    chk("m_state", 32'(ost), 32'(ms[d]));
    chk("m_err", 32'(oe), 32'(me[d]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_rst();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic       seq[15];
    logic [3:0] sts[15];
    logic       fexp[6];

    seq = '{1,1,1,1,0,1,0,1,1,0,0,1,0,0,0};
    sts = '{4'h1,4'h9,4'hD,4'hF,4'hE,4'h7,4'hA,4'h5,
            4'hB,4'hC,4'h6,4'h3,4'h8,4'h4,4'h2};
    fexp = '{1,0,1,0,1,1};
    for (int i = 0; i < 16; i++) begin
      tv[i].dout = {3'b0, seq[i % 15]};
      tv[i].ps   = (i % 15 == 0);
      tv[i].lane = 2'd0;
      tv[i].st   = sts[(i + 1) % 15];
    end
    tv[16] = '{4'b1111, 1'b1, 2'd0, 4'hE};
    tv[17] = '{4'b1010, 1'b0, 2'd0, 4'hB};
    tv[18] = '{4'b1001, 1'b0, 2'd0, 4'h8};
    tv[19] = '{4'b1000, 1'b1, 2'd3, 4'h9};

    bw[0] = 1; bw[1] = 4;
    ia.en = 0; ia.seed_load = 0; ia.seed = '0;
    ib.en = 0; ib.seed_load = 0; ib.seed = '0;
    model_rst();

    #12;
    sample(0);
    chk("rst_dout", 32'(od), 0);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_ps", 32'(ops), 0);
    chk("rst_state", 32'(ost), 1);
    chk("rst_err", 32'(oe), 0);
    #5 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(0, 1, 0, 4'h0);
      chk($sformatf("tbl1_dout%0d", i), 32'(od), 32'(tv[i].dout));
      chk($sformatf("tbl1_ps%0d", i), 32'(ops), 32'(tv[i].ps));
      chk($sformatf("tbl1_st%0d", i), 32'(ost), 32'(tv[i].st));
    end

    do_reset();
    for (int i = 16; i < 20; i++) begin
      apply(1, 1, 0, 4'h0);
      chk($sformatf("tbl4_dout%0d", i), 32'(od), 32'(tv[i].dout));
      chk($sformatf("tbl4_ps%0d", i), 32'(ops), 32'(tv[i].ps));
      chk($sformatf("tbl4_lane%0d", i), 32'(ol), 32'(tv[i].lane));
      chk($sformatf("tbl4_st%0d", i), 32'(ost), 32'(tv[i].st));
    end

    apply(0, 0, 1, 4'hF);
    chk("seedF_state", 32'(ost), 32'hF);
    chk("seedF_valid", 32'(ov), 0);
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 0, 4'h0);
      chk($sformatf("seedF_bit%0d", i), 32'(od), 32'(fexp[i]));
      chk($sformatf("seedF_ps%0d", i), 32'(ops), (i == 0) ? 1 : 0);
    end

    apply(0, 0, 1, 4'h0);
    chk("zseed_err", 32'(oe), 1);
    chk("zseed_state", 32'(ost), 1);
    apply(0, 1, 0, 4'h0);
    chk("zseed_err_clr", 32'(oe), 0);
    chk("zseed_bit", 32'(od), 1);
    chk("zseed_ps", 32'(ops), 1);

    apply(0, 1, 0, 4'h0);
    chk("tog_v1", 32'(ov), 1);
    apply(0, 0, 0, 4'h0);
    chk("tog_v0a", 32'(ov), 0);
    apply(0, 0, 0, 4'h0);
    chk("tog_v0b", 32'(ov), 0);
    apply(0, 1, 0, 4'h0);
    chk("tog_v1b", 32'(ov), 1);
    chk("tog_bit", 32'(od), 1);

    apply(1, 1, 1, 4'h6);
    chk("ldwin_state", 32'(ost), 6);
    chk("ldwin_valid", 32'(ov), 0);

    for (int i = 0; i < 3; i++) apply(1, 1, 0, 4'h0);
    #2 rst = 1'b1;
    model_rst();
    #1;
    sample(1);
    chk("mrst_dout", 32'(od), 0);
    chk("mrst_valid", 32'(ov), 0);
    chk("mrst_ps", 32'(ops), 0);
    chk("mrst_state", 32'(ost), 1);
    #2 rst = 1'b0;
    apply(1, 1, 0, 4'h0);
    chk("mrst_word", 32'(od), 32'hF);
    chk("mrst_ps1", 32'(ops), 1);
    chk("mrst_lane", 32'(ol), 0);

    for (int i = 0; i < 600; i++) begin
      int d;
      int r;
      d = i & 1;
      r = $urandom_range(0, 99);
      apply(d, r < 75, r >= 90, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
